// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared types and constants for the "1101" detector controller.
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    typedef enum logic [2:0] {
        DET_A = 3'd0,
        DET_B = 3'd1,
        DET_C = 3'd2,
        DET_D = 3'd3,
        DET_E = 3'd4
    } det_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    localparam logic [15:0] NO_MATCH_POS = 16'hFFFF;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl_if
// Purpose  : Word handshake and result bundle; first_pos exists only when
//            SEQ_DET_CTRL_FIRST_POS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_det_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              busy;
    logic              match_pulse;
    logic [CNT_W-1:0]  match_count;
    logic              frame_done;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
    logic [15:0]       first_pos;
`endif

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, busy, match_pulse, match_count, frame_done
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        , output first_pos
`endif
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, busy, match_pulse, match_count, frame_done
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        , input first_pos
`endif
    );

endinterface : seq_det_ctrl_if
`default_nettype wire

// File: rtl/seq_det_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_core
// Purpose  : Moore "1101" detector, advancing one bit per step; o=1 in E.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_core
    import seq_det_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic step,
    input  wire logic i,
    output logic      o
);

    det_state_t r_state;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= DET_A;
        end else if (step) begin
            case (r_state)
                DET_A:   r_state <= i ? DET_B : DET_A;
                DET_B:   r_state <= i ? DET_C : DET_A;
                DET_C:   r_state <= i ? DET_C : DET_D;
                DET_D:   r_state <= i ? DET_E : DET_A;
                DET_E:   r_state <= i ? DET_C : DET_A;
                default: r_state <= DET_A;
            endcase
        end
    end

    assign o = (r_state == DET_E);

endmodule : seq_det_core
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Purpose  : Serialises framed words MSB-first into seq_det_core and counts
//            matches per frame. SEQ_DET_CTRL_FIRST_POS_EN adds first_pos.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    seq_det_ctrl_if.slave  bus
);

    localparam int              c_bcw      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_bcw-1:0] c_bit_init = c_bcw'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    ctrl_state_t       r_state;
    logic [DATA_W-1:0] r_shreg;
    logic              r_last_q;
    logic [c_bcw-1:0]  r_bit_cnt;
    logic              r_new_frame;
    logic              r_step_d;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_match_count;

    logic w_step;
    logic w_clr;
    logic w_det_o;
    logic w_match_pulse;
    logic w_accept;

    assign w_step        = (r_state == ST_SHIFT);
    assign w_clr         = (r_state == ST_DONE);
    assign w_accept      = (r_state == ST_IDLE) && bus.in_valid;
    assign w_match_pulse = w_det_o & r_step_d;

    seq_det_core u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .step (w_step),
        .i    (r_shreg[DATA_W-1]),
        .o    (w_det_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shreg       <= '0;
            r_last_q      <= 1'b0;
            r_bit_cnt     <= '0;
            r_new_frame   <= 1'b1;
            r_step_d      <= 1'b0;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_match_count <= '0;
        end else begin
            r_step_d <= w_step;

            // A new frame's first accepted word restarts the count.
            if (w_accept && r_new_frame) begin
                r_match_count <= '0;
            end else if (w_match_pulse && (r_match_count != c_cnt_max)) begin
                r_match_count <= r_match_count + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_shreg     <= bus.in_data;
                        r_last_q    <= bus.in_last;
                        r_bit_cnt   <= c_bit_init;
                        r_new_frame <= 1'b0;
                        r_state     <= ST_SHIFT;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= r_shreg << 1;
                    if (r_bit_cnt == '0) begin
                        if (r_last_q) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state      <= ST_DONE;
                    r_frame_done <= 1'b1;
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_frame_done <= 1'b0;
                    r_new_frame  <= 1'b1;
                    r_in_ready   <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.busy        = r_busy;
    assign bus.match_pulse = w_match_pulse;
    assign bus.match_count = r_match_count;
    assign bus.frame_done  = r_frame_done;

`ifdef SEQ_DET_CTRL_FIRST_POS_EN
    logic [15:0] r_bit_pos;
    logic [15:0] r_last_pos;
    logic [15:0] r_first_pos;

    // r_last_pos remembers the index of the bit just stepped, which is the
    // completing bit when match_pulse fires a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_pos   <= '0;
            r_last_pos  <= '0;
            r_first_pos <= NO_MATCH_POS;
        end else begin
            if (w_accept && r_new_frame) begin
                r_bit_pos   <= '0;
                r_first_pos <= NO_MATCH_POS;
            end else begin
                if (w_step) begin
                    r_last_pos <= r_bit_pos;
                    if (r_bit_pos != 16'hFFFF) begin
                        r_bit_pos <= r_bit_pos + 16'd1;
                    end
                end
                if (w_match_pulse && (r_first_pos == NO_MATCH_POS)) begin
                    r_first_pos <= r_last_pos;
                end
            end
        end
    end

    assign bus.first_pos = r_first_pos;
`endif

endmodule : seq_det_ctrl
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Purpose  : Directed self-checking bench for seq_det_ctrl (CNT_W=8 and a
//            CNT_W=2 saturation copy driven in lockstep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       last  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    int fd_cnt   = 0;

    always #5 clk = ~clk;

    seq_det_ctrl_if #(.DATA_W(8), .CNT_W(8)) bus8 ();
    seq_det_ctrl_if #(.DATA_W(8), .CNT_W(2)) bus2 ();

    assign bus8.in_valid = valid;
    assign bus8.in_data  = data;
    assign bus8.in_last  = last;
    assign bus2.in_valid = valid;
    assign bus2.in_data  = data;
    assign bus2.in_last  = last;

    seq_det_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    seq_det_ctrl #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    always @(negedge clk) begin
        if (bus8.match_pulse) pulses = pulses + 1;
        if (bus8.frame_done)  fd_cnt = fd_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns #1 after the accepting posedge.
    task automatic send(input logic [7:0] d, input logic l);
        int k = 0;
        while (!bus8.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus8.in_ready) check_val("ready_timeout", 32'd0, 32'd1);
        valid = 1'b1;
        data  = d;
        last  = l;
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = 8'hFF;
        last  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus8.frame_done) break;
        end
        if (!bus8.frame_done) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p0;
        int fd0;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_in_ready",    bus8.in_ready,    1);
        check_val("rst_busy",        bus8.busy,        0);
        check_val("rst_match_pulse", bus8.match_pulse, 0);
        check_val("rst_match_count", bus8.match_count, 0);
        check_val("rst_frame_done",  bus8.frame_done,  0);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        check_val("rst_first_pos",   bus8.first_pos,   NO_MATCH_POS);
`endif
        rst = 1'b0;
        @(negedge clk);

        // D0 single word; in_valid held during SHIFT must be ignored
        p0 = pulses;
        send(8'hD0, 1'b1);
        valid = 1'b1; data = 8'hFF; last = 1'b1;
        @(negedge clk);
        check_val("d0_busy",     bus8.busy,     1);
        check_val("d0_in_ready", bus8.in_ready, 0);
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
        wait_done(lat);
        check_val("d0_latency", lat + 2, 10);
        check_val("d0_pulses",  pulses - p0, 1);
        check_val("d0_count",   bus8.match_count, 1);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        check_val("d0_first_pos", bus8.first_pos, 3);
`endif
        @(negedge clk);
        check_val("d0_done_one_cycle", bus8.frame_done, 0);
        check_val("d0_idle_ready",     bus8.in_ready,   1);

        // DB: overlapping matches
        p0 = pulses;
        send(8'hDB, 1'b1);
        wait_done(lat);
        check_val("db_latency", lat, 10);
        check_val("db_pulses",  pulses - p0, 2);
        check_val("db_count",   bus8.match_count, 2);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        check_val("db_first_pos", bus8.first_pos, 3);
`endif
        @(negedge clk);

        // Pattern spanning a word boundary, back-to-back words
        send(8'h03, 1'b0);
        send(8'h40, 1'b1);
        wait_done(lat);
        check_val("span_count", bus8.match_count, 1);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        check_val("span_first_pos", bus8.first_pos, 9);
`endif
        repeat (3) @(negedge clk);
        check_val("span_count_hold", bus8.match_count, 1);

        // Same frame with a 5-cycle gap between words
        send(8'h03, 1'b0);
        repeat (14) @(negedge clk);
        check_val("gap_busy",  bus8.busy,        0);
        check_val("gap_count", bus8.match_count, 0);
        send(8'h40, 1'b1);
        wait_done(lat);
        check_val("gap_result", bus8.match_count, 1);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        check_val("gap_first_pos", bus8.first_pos, 9);
`endif
        @(negedge clk);

        // Two separate frames: detector cleared between them
        send(8'h03, 1'b1);
        wait_done(lat);
        check_val("frame_a_count", bus8.match_count, 0);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        check_val("frame_a_first_pos", bus8.first_pos, NO_MATCH_POS);
`endif
        @(negedge clk);
        send(8'h40, 1'b1);
        wait_done(lat);
        check_val("frame_b_count", bus8.match_count, 0);
        @(negedge clk);

        // Four DB words: 8 matches, saturating copy stops at 3
        p0 = pulses;
        send(8'hDB, 1'b0);
        send(8'hDB, 1'b0);
        send(8'hDB, 1'b0);
        send(8'hDB, 1'b1);
        wait_done(lat);
        check_val("sat_pulses",    pulses - p0, 8);
        check_val("sat_count_w8",  bus8.match_count, 8);
        check_val("sat_count_w2",  bus2.match_count, 3);
        check_val("sat_done_w2",   bus2.frame_done,  1);
        @(negedge clk);

        // Reset in the middle of SHIFT
        send(8'hD0, 1'b1);
        repeat (6) @(negedge clk);
        check_val("prerst_count", bus8.match_count, 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_in_ready", bus8.in_ready,    1);
        check_val("mrst_busy",     bus8.busy,        0);
        check_val("mrst_count",    bus8.match_count, 0);
        check_val("mrst_done",     bus8.frame_done,  0);
        check_val("mrst_pulse",    bus8.match_pulse, 0);
        rst = 1'b0;
        fd0 = fd_cnt;
        repeat (15) @(negedge clk);
        check_val("mrst_no_done", fd_cnt - fd0, 0);
        send(8'hD0, 1'b1);
        wait_done(lat);
        check_val("post_rst_latency", lat, 10);
        check_val("post_rst_count",   bus8.match_count, 1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_det_ctrl
`default_nettype wire
